// File: rtl/key_event_tracker.sv
// key_event_tracker: PS/2 set-2 scan-code parser with held-key table,
// press statistics, overflow flags and a first-word-fall-through event FIFO.
// Event word layout: {rpt, ext, brk, code[7:0]}.
// Optional feature macro: KEY_REPEAT_EVENT_EN -- when defined, a typematic
// repeat of a held key pushes an event with rpt=1; otherwise repeats are
// dropped and rpt is always 0.
module key_event_tracker #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int MAX_KEYS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           ev_valid,
  output logic [10:0]                    ev_data,
  input  logic                           ev_pop,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]               press_count,
  output logic [$clog2(MAX_KEYS+1)-1:0]  held_count,
  output logic [8:0]                     last_code,
  output logic                           fifo_ovf,
  output logic                           table_ovf,
  input  logic                           clr_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(MAX_KEYS + 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t state, state_nxt;

  // Host-protocol bytes (ack, BAT, echo, resend, error) carry no key
  // information when they arrive outside a prefix sequence.
  function automatic logic is_noise(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // ---- stage p0: parser decode of the incoming byte ----
  logic       key_vld_p0;
  logic       key_ext_p0;
  logic       key_brk_p0;
  logic [8:0] key_p0;

  // Parser state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Parser next-state: prefixes accumulate, anything else completes a key
  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      if (in_data == 8'hE0) begin
        state_nxt = EXT;
      end else if (in_data == 8'hF0) begin
        if (state == IDLE)     state_nxt = BRK;
        else if (state == EXT) state_nxt = EXT_BRK;
      end else if (!((state == IDLE) && is_noise(in_data))) begin
        state_nxt = IDLE;
      end
    end
  end

  // Parser outputs: completed key strobe with prefix flags from current state
  always_comb begin
    key_vld_p0 = 1'b0;
    key_ext_p0 = (state == EXT) || (state == EXT_BRK);
    key_brk_p0 = (state == BRK) || (state == EXT_BRK);
    if (in_valid && (in_data != 8'hE0) && (in_data != 8'hF0) &&
        !((state == IDLE) && is_noise(in_data)))
      key_vld_p0 = 1'b1;
  end

  assign key_p0 = {key_ext_p0, in_data};

  // ---- held-key table lookup ----
  logic [MAX_KEYS-1:0] tbl_vld;
  logic [8:0]          tbl_key [MAX_KEYS];
  logic [MAX_KEYS-1:0] hit_vec;
  logic [MAX_KEYS-1:0] free_sel;
  logic                free_found;

  // Match against occupied entries and pick the lowest free slot
  always_comb begin
    hit_vec    = '0;
    free_sel   = '0;
    free_found = 1'b0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (tbl_vld[i] && (tbl_key[i] == key_p0)) hit_vec[i] = 1'b1;
      if (!tbl_vld[i] && !free_found) begin
        free_sel[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  logic is_make, is_brk, is_hit, is_new;
  logic do_insert, do_remove, tbl_ovf_set;
  logic push, key_rpt_p0;
  logic [10:0] ev_word;

  assign is_make     = key_vld_p0 && !key_brk_p0;
  assign is_brk      = key_vld_p0 &&  key_brk_p0;
  assign is_hit      = |hit_vec;
  assign is_new      = is_make && !is_hit;
  assign do_insert   = is_new && free_found;
  assign tbl_ovf_set = is_new && !free_found;
  assign do_remove   = is_brk;

`ifdef KEY_REPEAT_EVENT_EN
  assign key_rpt_p0 = is_make && is_hit;
  assign push       = is_new || is_brk || key_rpt_p0;
`else
  assign key_rpt_p0 = 1'b0;
  assign push       = is_new || is_brk;
`endif

  assign ev_word = {key_rpt_p0, key_ext_p0, key_brk_p0, in_data};

  // ---- stage p1: registered table, statistics and event FIFO ----
  // Table occupancy: release on break, claim lowest free slot on new make
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_vld <= '0;
    end else begin
      for (int i = 0; i < MAX_KEYS; i++) begin
        if (do_remove && hit_vec[i])  tbl_vld[i] <= 1'b0;
        if (do_insert && free_sel[i]) tbl_vld[i] <= 1'b1;
      end
    end
  end

  // Table key storage; only meaningful where tbl_vld is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_KEYS; i++)
      if (do_insert && free_sel[i]) tbl_key[i] <= key_p0;
  end

  // Occupied-entry count
  always_comb begin
    held_count = '0;
    for (int i = 0; i < MAX_KEYS; i++)
      held_count = held_count + HW'(tbl_vld[i]);
  end

  logic [10:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, wr_en;

  assign ev_valid = (fifo_count != '0);
  assign pop      = ev_pop && ev_valid;
  assign full     = (fifo_count == FULL_CNT);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_en    = push && (!full || pop);
  // Head is forced to zero when empty so stale storage never shows
  assign ev_data  = ev_valid ? fifo_mem[rd_ptr] : '0;

  // FIFO pointers and occupancy; pointers wrap at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= ev_word;
  end

  // Press statistics and sticky overflow flags (a new overflow beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      press_count <= '0;
      last_code   <= '0;
      fifo_ovf    <= 1'b0;
      table_ovf   <= 1'b0;
    end else begin
      if (is_new) begin
        press_count <= press_count + 1'b1;
        last_code   <= key_p0;
      end
      if (push && full && !pop) fifo_ovf <= 1'b1;
      else if (clr_ovf)         fifo_ovf <= 1'b0;
      if (tbl_ovf_set)          table_ovf <= 1'b1;
      else if (clr_ovf)         table_ovf <= 1'b0;
    end
  end

endmodule

// File: doc/key_event_tracker.md
KEY_EVENT_TRACKER -- requirements
Module: key_event_tracker

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth; power of 2, minimum 2.
REQ-002 The block SHALL have parameter CNT_W, default 8, press counter width.
REQ-003 The block SHALL have parameter MAX_KEYS, default 4, held-key table entries; minimum 1.
REQ-004 The block SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 The block SHALL have port in_valid  in  1  one-cycle strobe: in_data holds a received scan-code byte.
REQ-007 The block SHALL have port in_data  in  8  scan-code byte.
REQ-008 The block SHALL have port ev_valid  out  1  FIFO non-empty.
REQ-009 The block SHALL have port ev_data  out  11  FIFO head {rpt, ext, brk, code[7:0]}, first-word-fall-through.
REQ-010 The block SHALL have port ev_pop  in  1  consume head; ignored when ev_valid=0.
REQ-011 The block SHALL have port fifo_count  out  clog2(FIFO_DEPTH)+1  stored events.
REQ-012 The block SHALL have port press_count  out  CNT_W  accepted new presses, modulo 2^CNT_W.
REQ-013 The block SHALL have port held_count  out  clog2(MAX_KEYS+1)  occupied table entries.
REQ-014 The block SHALL have port last_code  out  9  {ext, code} of the most recent accepted new press.
REQ-015 The block SHALL have port fifo_ovf  out  1  sticky: event dropped, FIFO full.
REQ-016 The block SHALL have port table_ovf  out  1  sticky: new press, table full.
REQ-017 The block SHALL have port clr_ovf  in  1  clears both sticky flags.

Function
REQ-018 The parser SHALL have states IDLE, EXT, BRK and EXT_BRK, and SHALL advance only on in_valid.
REQ-019 Parser transitions SHALL be: E0 from any state -> EXT; F0 from IDLE -> BRK; F0 from EXT -> EXT_BRK; F0 from BRK or EXT_BRK -> no state change.
REQ-020 Any other byte in any state SHALL complete a key {ext, brk, code}, with ext/brk taken from the current state, and the parser SHALL return to IDLE.
REQ-021 Bytes 00, AA, EE, FA, FE and FF received in IDLE SHALL be discarded with no state change; in other states they SHALL be treated as key codes.
REQ-022 On a make whose {ext, code} is in the held table, the make SHALL be a repeat: no event, no count, no table change (see REQ-034).
REQ-023 On a make not in the table, the block SHALL insert it into a free entry, increment press_count, update last_code and push an event with rpt=0.
REQ-024 On a make not in the table while the table is full, the block SHALL set table_ovf, increment press_count, update last_code and push the event, but SHALL NOT insert the key.
REQ-025 On a break, the block SHALL remove the matching entry if present and SHALL push the event; press_count SHALL be unchanged.
REQ-026 An event SHALL be visible on ev_valid/ev_data in the cycle after the in_valid that carried the final byte, provided the FIFO was empty.
REQ-027 A push with the FIFO full and no pop in the same cycle SHALL drop the event and set fifo_ovf.
REQ-028 A simultaneous push and pop when full SHALL both succeed, leaving fifo_count unchanged.
REQ-029 A simultaneous push and pop when empty SHALL leave ev_valid=1 on the next cycle.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 If clr_ovf coincides with a new overflow condition, the flag SHALL end set (set wins).
REQ-032 press_count SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-033 While rst=1 on a clock edge, the block SHALL return the parser to IDLE, empty the table and FIFO, zero all outputs including ev_data, and ignore in_valid, ev_pop and clr_ovf.

Configuration
REQ-034 With KEY_REPEAT_EVENT_EN defined, a repeat make SHALL push an event with rpt=1 (no count, no table change); without it, repeats SHALL be silently dropped and rpt SHALL be constant 0.

Verification
REQ-035 The bench SHALL cover: bytes 1C, F0, 1C -> events 0_0_0_1C then 0_0_1_1C; press_count=1; held_count 1 then 0.
REQ-036 The bench SHALL cover: E0, 75, E0, F0, 75 -> events 0_1_0_75 and 0_1_1_75; last_code=175.
REQ-037 The bench SHALL cover: 1C, 1C, 1C (typematic) -> one event and press_count=1 without macro; with macro, two further events with rpt=1.
REQ-038 The bench SHALL cover: MAX_KEYS=4, makes 15, 1D, 24, 2D, 2C -> table_ovf=1, held_count=4, press_count=5, 5 events.
REQ-039 The bench SHALL cover: FIFO_DEPTH=8 and 9 makes with no pop -> fifo_count=8, fifo_ovf=1, head=first key; clr_ovf pulse -> fifo_ovf=0.
REQ-040 The bench SHALL cover: rst asserted after E0, F0 -> next byte 1C produces 0_0_0_1C; all counters 0.
